// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 slave receiver: rebuilds a 14-bit counter from a 2-byte SS-framed transfer.
// Optional macro SPI_RX_PAD_CHECK_EN rejects frames whose high-byte pad bits [7:6] are nonzero.
`timescale 1ns/1ps
module spi_counter_slave_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic [13:0] o_counter,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, RX_HIGH, RX_LOW, WAIT_END} state_t;

`ifdef SPI_RX_PAD_CHECK_EN
  localparam logic PAD_CHECK = 1'b1;
`else
  localparam logic PAD_CHECK = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, fill;
  logic sclk_prev, ss_prev;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, ss_fall, ss_rise;
  logic armed, overrun, pad_ok;
  state_t state;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic [7:0] high_reg, low_reg;

  assign miso = 1'b0;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign ss_rise   = ss_s & ~ss_prev;

  assign pad_ok = !PAD_CHECK || (high_reg[7:6] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      // Arm only on a real sampled ss high, not the reset value still flushing out of the chain.
      if (fill[SYNC_STAGES-1] && ss_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      high_reg    <= '0;
      low_reg     <= '0;
      overrun     <= 1'b0;
      o_counter   <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (ss_rise) begin
        // ss_rise outranks a coincident sclk_rise, so that bit is dropped.
        if (state == WAIT_END && !overrun && pad_ok) begin
          o_counter <= {high_reg[5:0], low_reg};
          o_valid   <= 1'b1;
        end else if (state != IDLE) begin
          o_frame_err <= 1'b1;
        end
        state   <= IDLE;
        o_busy  <= 1'b0;
        overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall && armed) begin
              shift   <= '0;
              bit_cnt <= '0;
              o_busy  <= 1'b1;
              state   <= RX_HIGH;
            end
          end
          RX_HIGH: begin
            if (sclk_rise) begin
              shift   <= {shift[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                high_reg <= {shift, mosi_s};
                bit_cnt  <= '0;
                state    <= RX_LOW;
              end
            end
          end
          RX_LOW: begin
            if (sclk_rise) begin
              shift   <= {shift[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                low_reg <= {shift, mosi_s};
                bit_cnt <= '0;
                state   <= WAIT_END;
              end
            end
          end
          WAIT_END: begin
            if (sclk_rise) overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Self-checking bench for spi_counter_slave_rx: directed and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_spi_counter_slave_rx;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic reset, sclk, mosi, ss, miso;
  logic [13:0] o_counter;
  logic o_valid, o_frame_err, o_busy;

  always #5 clk = ~clk;

  spi_counter_slave_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .o_counter(o_counter), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  typedef struct {
    int         cyc;
    bit         valid;
    logic [13:0] val;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int cyc = 0;
  int both_cnt = 0;
  int passes = 0;
  int fails = 0;
  int total = 0;
  logic [13:0] model_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (o_valid) begin
      e.cyc = cyc; e.valid = 1'b1; e.val = o_counter;
      obs_q.push_back(e);
    end
    if (o_frame_err) begin
      e.cyc = cyc; e.valid = 1'b0; e.val = o_counter;
      obs_q.push_back(e);
    end
    if (o_valid && o_frame_err) both_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_ok(input logic [7:0] hi, input int nbits);
    bit ok;
    ok = (nbits == 16);
`ifdef SPI_RX_PAD_CHECK_EN
    ok = ok && (hi[7:6] == 2'b00);
`else
    ok = ok && (hi == hi);
`endif
    return ok;
  endfunction

  task automatic send_bit(input logic b, input int half);
    mosi = b;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] hi, input logic [7:0] lo, input int nbits, input int half);
    logic [15:0] w;
    ev_t e;
    w = {hi, lo};
    @(negedge clk);
    ss = 1'b0;
    repeat (S + 2) @(negedge clk);
    chk("busy_in_frame", {31'd0, o_busy}, 32'd1);
    for (int i = 0; i < nbits; i++)
      send_bit((i < 16) ? w[15 - i] : 1'($urandom_range(1)), half);
    repeat (half) @(negedge clk);
    ss = 1'b1;
    e.cyc = cyc + int'(S) + 1;
    if (frame_ok(hi, nbits)) begin
      model_cnt = w[13:0];
      e.valid = 1'b1;
    end else begin
      e.valid = 1'b0;
    end
    e.val = model_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_events(input string tag);
    ev_t o, x;
    repeat (S + 4) @(negedge clk);
    chk({tag, "_nevents"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_cycle"}, o.cyc, x.cyc);
      chk({tag, "_kind"}, {31'd0, o.valid}, {31'd0, x.valid});
      chk({tag, "_value"}, {18'd0, o.val}, {18'd0, x.val});
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_busy_idle"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_exclusive"}, both_cnt, 0);
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0] hi, lo;
    int nb, hf;

    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_counter", {18'd0, o_counter}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_err", {31'd0, o_frame_err}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    frame(8'h00, 8'h2A, 16, 5);
    check_events("basic");
    chk("basic_counter", {18'd0, o_counter}, 32'h002A);

    frame(8'h12, 8'h34, 11, 3);
    check_events("short");
    chk("short_counter", {18'd0, o_counter}, 32'h002A);

    frame(8'h15, 8'h55, 17, 3);
    check_events("long");
    chk("long_counter", {18'd0, o_counter}, 32'h002A);

    frame(8'h3F, 8'hFF, 16, 3);
    frame(8'h00, 8'h00, 16, 3);
    check_events("maxzero");
    chk("maxzero_counter", {18'd0, o_counter}, 32'h0000);

    frame(8'h00, 8'h77, 16, 3);
    frame(8'hC1, 8'h23, 16, 3);
    check_events("pad");
`ifdef SPI_RX_PAD_CHECK_EN
    chk("pad_counter", {18'd0, o_counter}, 32'h0077);
`else
    chk("pad_counter", {18'd0, o_counter}, 32'h0123);
`endif

    // Reset in the middle of a frame with ss held low through release.
    w = 16'hABCD;
    @(negedge clk);
    ss = 1'b0;
    repeat (S + 2) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(w[15 - i], 3);
    reset = 1'b1;
    model_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rstmid_busy", {31'd0, o_busy}, 32'd0);
    reset = 1'b0;
    for (int i = 5; i < 16; i++) send_bit(w[15 - i], 3);
    repeat (3) @(negedge clk);
    chk("rstmid_busy_after", {31'd0, o_busy}, 32'd0);
    ss = 1'b1;
    check_events("rstmid");
    chk("rstmid_counter", {18'd0, o_counter}, 32'h0000);
    frame(8'h12, 8'h34, 16, 4);
    check_events("post_rst");
    chk("post_rst_counter", {18'd0, o_counter}, 32'h1234);

    for (int k = 0; k < 12; k++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      nb = ($urandom_range(3) == 0) ? int'($urandom_range(20, 1)) : 16;
      hf = int'($urandom_range(5, 3));
      frame(hi, lo, nb, hf);
      if (k % 3 == 2) check_events("random");
    end
    check_events("random_tail");
    chk("random_counter", {18'd0, o_counter}, {18'd0, model_cnt});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
